dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined CPU's MEM stage. It accepts word read/write requests over a valid/ready handshake, performs each access after a fixed, parameterised wait, and returns a one-cycle response pulse. While a request is in flight it drives `busy`, which the hazard logic uses to stall the pipeline. A registered debug port lets the board switches and LEDs inspect any memory word independently of CPU traffic.

## Interface
- `ADDR_WIDTH`, 8: word-address bits; memory depth is 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, 2: wait cycles between acceptance and the memory access; legal range 1..15.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: a request is present.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 32: byte address; the word index is `req_addr[ADDR_WIDTH+1:2]`.
- `req_wdata` in 32: write data.
- `req_ready` out 1: the responder can accept a request this cycle.
- `resp_valid` out 1: one-cycle completion pulse for both reads and writes.
- `resp_rdata` out 32: read data; valid while `resp_valid` is high.
- `busy` out 1: a request is in flight (stall request to the hazard logic).
- `show_addr` in 32: debug byte address; the word index is `show_addr[ADDR_WIDTH+1:2]`.
- `show_data` out 32: registered debug read data.
- `misalign_err` out 1: sticky flag, set when a request with `req_addr[1:0] != 0` is accepted.

## Operation
- **States.**
  - IDLE: `req_ready`=1, `busy`=0.
  - WAIT: `req_ready`=0, `busy`=1.
  - RESP: `req_ready`=0, `busy`=1, `resp_valid`=1.
- **IDLE.** When `req_valid` is high at a rising edge:
  - capture we, word index, wdata and the misalign bit;
  - load the 4-bit wait counter with `LATENCY-1`;
  - go to WAIT.
  - With `req_valid` low, stay in IDLE.
- **WAIT.** The counter decrements each edge. At the edge where counter==0:
  - perform the access:
    - write → `mem[idx] <= wdata`;
    - read → `resp_rdata <= mem[idx]`;
  - go to RESP.
- **RESP.** Lasts exactly one cycle, then returns to IDLE. Inputs are ignored during RESP.
- **Writes.** `resp_rdata` holds its previous value.
- **Misaligned request.** Accepted and acknowledged normally, but:
  - write → no memory update;
  - read → `resp_rdata` = 0;
  - `misalign_err` is set and stays set until reset.
- **Address wrap.** Address bits above `ADDR_WIDTH+1` are ignored, so addresses wrap modulo the memory size.
- **Request fields.** `req_*` values are sampled only at the accept edge; later changes have no effect on the captured request.
- **Debug port.** `show_data <= mem[show_idx]` every edge, in every state. If the same edge writes the same word, `show_data` returns the old value (read-before-write).
- **Reset.** Asynchronous; takes effect immediately.
  - State → IDLE, counter → 0.
  - `resp_valid`=0, `resp_rdata`=0, `show_data`=0, `misalign_err`=0.
  - `req_ready`=1 and `busy`=0 once reset is removed.
  - Memory contents are not cleared.
  - Reset mid-operation: a pending request is abandoned. A pending write never reaches memory; no `resp_valid` is produced.

## Timing
- **Request timing.** For a request accepted at edge E0:
  - memory access at edge E(LATENCY);
  - `resp_valid` high for the cycle after E(LATENCY);
  - IDLE again after E(LATENCY+1);
  - next accept at E(LATENCY+2) at the earliest.
- **Throughput.** One request per `LATENCY+2` cycles.
- **Busy window.** `busy` is high from the cycle after E0 through the RESP cycle, i.e. `LATENCY+1` cycles.
- **Combinational outputs.** `req_ready` and `busy` are decoded from state only; they have no combinational path from `req_valid`.
- **Debug latency.** `show_data` has one-cycle latency from `show_addr`.
- **Write visibility.** A read issued after a write's RESP cycle returns the written data.

## Test plan
- **Write then read** (`LATENCY`=2). Write `0xDEADBEEF` to 0x10, then read 0x10.
  - `resp_valid` pulses 3 cycles after each accept edge.
  - The read returns `0xDEADBEEF`.
  - `busy` is high for 3 cycles per request.
- **Back-to-back requests.** Hold `req_valid` high for 3 consecutive write requests.
  - Exactly one accept per 4 cycles; `req_ready` is low in WAIT and RESP.
  - All 3 words read back correctly.
- **Misaligned and wrapped accesses.**
  - Write `0x12345678` to 0x11 → ack pulses, `misalign_err`=1, word 0x10 is unchanged; a read of 0x13 returns 0.
  - Write to 0x410 (`ADDR_WIDTH`=8) → data appears at 0x010.
- **Debug port.**
  - `show_addr`=0x20 after writing `0xA5A5A5A5` there → `show_data`=`0xA5A5A5A5` one cycle later.
  - Set `show_addr`=0x20 while a write of `0x1` to 0x20 lands → old value for one cycle, then `0x1`.
- **Reset mid-write.** Assert `rst` during WAIT of a write of `0xFFFFFFFF` to 0x30.
  - Outputs go to reset values immediately; no `resp_valid`.
  - A subsequent read of 0x30 returns the prior contents.
- **`LATENCY`=1 build.** A read returns data with `resp_valid` 2 cycles after accept; throughput is 1 request per 3 cycles.

Source files
------------

// File: rtl/dmem_responder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_responder_if                                                     |
// | Request/response bus between the MEM stage and the data responder.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        busy;
  logic        misalign_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, busy, misalign_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, busy, misalign_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_responder                                                        |
// | Fixed-latency word memory with valid/ready requests and a debug port. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module dmem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic               clk,
  input  logic               rst,
  dmem_responder_if.slave    bus,
  input  logic [31:0]        show_addr,
  output logic [31:0]        show_data
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    mis_q, mis_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [31:0]             show_q, show_d;

  logic [31:0]             mem [DEPTH];

  logic                    ready;
  logic                    busy;
  logic                    resp_valid;
  logic                    access;
  logic                    mem_we;
  logic                    req_mis;
  logic                    unused_addr_bits;

  assign req_mis          = |bus.req_addr[1:0];
  assign unused_addr_bits = ^{show_addr[31:ADDR_WIDTH+2], show_addr[1:0],
                              bus.req_addr[31:ADDR_WIDTH+2]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    mis_d      = mis_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    ready      = 1'b0;
    busy       = 1'b0;
    resp_valid = 1'b0;
    access     = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          idx_d   = bus.req_addr[ADDR_WIDTH+1:2];
          wdata_d = bus.req_wdata;
          mis_d   = req_mis;
          err_d   = err_q | req_mis;
          cnt_d   = LAT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = S_RESP;
          // Misaligned reads return zero rather than the aligned word.
          if (!we_q) begin
            rdata_d = mis_q ? 32'd0 : mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_we = access & we_q & ~mis_q;
  assign show_d = mem[show_addr[ADDR_WIDTH+1:2]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      mis_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      show_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      show_q  <= show_d;
    end
  end

  // Contents survive reset; show_d samples the pre-write value on a same-edge hit.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.req_ready    = ready;
  assign bus.busy         = busy;
  assign bus.resp_valid   = resp_valid;
  assign bus.resp_rdata   = rdata_q;
  assign bus.misalign_err = err_q;
  assign show_data        = show_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_dmem_responder                                                     |
// | Scoreboard bench for LATENCY=2 and LATENCY=1 builds of the responder. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int PERIOD = 10;

  typedef struct {
    logic [31:0] rdata;
    longint      t_acc;
  } entry_t;

  logic        clk;
  logic        rst;
  logic [31:0] show_addr;
  logic [31:0] show_data;
  logic [31:0] show_data1;

  int          tests;
  int          fails;
  int          bcnt0;
  int          bcnt1;
  logic [31:0] last_rd0;
  logic [31:0] last_rd1;
  entry_t      q0[$];
  entry_t      q1[$];

  dmem_responder_if if0 ();
  dmem_responder_if if1 ();

  dmem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .bus       (if0),
    .show_addr (show_addr),
    .show_data (show_data)
  );

  dmem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (if1),
    .show_addr (32'h0),
    .show_data (show_data1)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_resp(input int sel, input logic [31:0] rd, input int bc);
    entry_t e;
    int     lat;
    bit     have;
    longint dt;
    lat  = (sel != 0) ? 1 : 2;
    have = 1'b0;
    if (sel == 0 && q0.size() > 0) begin
      e = q0.pop_front(); have = 1'b1;
    end else if (sel != 0 && q1.size() > 0) begin
      e = q1.pop_front(); have = 1'b1;
    end
    if (!have) begin
      tests++;
      fails++;
      $display("FAIL unexpected_resp: dut%0d resp_valid=1 required=0 at t=%0t", sel, $time);
    end else begin
      dt = (longint'($time) - e.t_acc) / PERIOD;
      cmp("resp_latency", 32'(dt), 32'(lat + 1));
      cmp("busy_cycles", 32'(bc), 32'(lat + 1));
      cmp("resp_rdata", rd, e.rdata);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      bcnt0 = 0;
    end else begin
      if (if0.busy) bcnt0++;
      if (if0.resp_valid) begin
        check_resp(0, if0.resp_rdata, bcnt0);
        bcnt0 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      bcnt1 = 0;
    end else begin
      if (if1.busy) bcnt1++;
      if (if1.resp_valid) begin
        check_resp(1, if1.resp_rdata, bcnt1);
        bcnt1 = 0;
      end
    end
  end

  // Drives a request, waits for acceptance and queues the expected response.
  // Returns right after the accept edge with req_valid still asserted.
  task automatic issue(input int sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp,
                       output longint t_acc, output int nwait);
    entry_t e;
    bit     ok;
    nwait = 0;
    ok    = 1'b1;
    @(negedge clk);
    if (sel != 0) begin
      if1.req_we = we; if1.req_addr = addr; if1.req_wdata = wdata; if1.req_valid = 1'b1;
    end else begin
      if0.req_we = we; if0.req_addr = addr; if0.req_wdata = wdata; if0.req_valid = 1'b1;
    end
    while (!((sel != 0) ? if1.req_ready : if0.req_ready)) begin
      @(negedge clk);
      nwait++;
      if (nwait > 50) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: dut%0d req_ready=0 required=1", sel);
        ok = 1'b0;
        break;
      end
    end
    t_acc = longint'($time);
    if (ok) begin
      e.t_acc = t_acc;
      if (sel != 0) begin
        e.rdata = we ? last_rd1 : exp;
        if (!we) last_rd1 = exp;
        q1.push_back(e);
      end else begin
        e.rdata = we ? last_rd0 : exp;
        if (!we) last_rd0 = exp;
        q0.push_back(e);
      end
    end
    @(posedge clk);
  endtask

  task automatic drain(input int sel);
    int n;
    n = 0;
    @(negedge clk);
    if (sel != 0) if1.req_valid = 1'b0;
    else          if0.req_valid = 1'b0;
    while ((((sel != 0) ? q1.size() : q0.size()) != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: dut%0d pending=%0d required=0", sel,
               (sel != 0) ? q1.size() : q0.size());
    end
  endtask

  initial begin
    longint t1, t2, t3;
    int     n1, n2, n3;
    tests = 0; fails = 0;
    bcnt0 = 0; bcnt1 = 0;
    last_rd0 = 32'd0; last_rd1 = 32'd0;
    rst = 1'b1;
    show_addr = 32'h0;
    if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_addr = 32'h0; if0.req_wdata = 32'h0;
    if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_addr = 32'h0; if1.req_wdata = 32'h0;

    repeat (2) @(negedge clk);
    cmp("rst_resp_valid", {31'd0, if0.resp_valid}, 32'd0);
    cmp("rst_resp_rdata", if0.resp_rdata, 32'd0);
    cmp("rst_show_data", show_data, 32'd0);
    cmp("rst_misalign", {31'd0, if0.misalign_err}, 32'd0);
    rst = 1'b0;
    #1;
    cmp("rst_ready", {31'd0, if0.req_ready}, 32'd1);
    cmp("rst_busy", {31'd0, if0.busy}, 32'd0);

    // Write then read
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, t1, n1);
    issue(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, t1, n1);
    drain(0);

    // Back-to-back writes with req_valid held high
    issue(0, 1'b1, 32'h40, 32'h11111111, 32'h0, t1, n1);
    issue(0, 1'b1, 32'h44, 32'h22222222, 32'h0, t2, n2);
    issue(0, 1'b1, 32'h48, 32'h33333333, 32'h0, t3, n3);
    drain(0);
    cmp("b2b_spacing_1", 32'((t2 - t1) / PERIOD), 32'd4);
    cmp("b2b_spacing_2", 32'((t3 - t2) / PERIOD), 32'd4);
    cmp("b2b_ready_low_1", 32'(n2), 32'd3);
    cmp("b2b_ready_low_2", 32'(n3), 32'd3);
    issue(0, 1'b0, 32'h40, 32'h0, 32'h11111111, t1, n1);
    issue(0, 1'b0, 32'h44, 32'h0, 32'h22222222, t1, n1);
    issue(0, 1'b0, 32'h48, 32'h0, 32'h33333333, t1, n1);
    drain(0);

    // Misaligned write is acknowledged but leaves memory untouched
    issue(0, 1'b1, 32'h11, 32'h12345678, 32'h0, t1, n1);
    drain(0);
    cmp("misalign_set", {31'd0, if0.misalign_err}, 32'd1);
    issue(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, t1, n1);
    issue(0, 1'b0, 32'h13, 32'h0, 32'h00000000, t1, n1);
    drain(0);
    cmp("misalign_sticky", {31'd0, if0.misalign_err}, 32'd1);

    // Address wrap: 0x410 aliases word 0x010
    issue(0, 1'b1, 32'h410, 32'hCAFEF00D, 32'h0, t1, n1);
    issue(0, 1'b0, 32'h010, 32'h0, 32'hCAFEF00D, t1, n1);
    drain(0);

    // Debug port
    issue(0, 1'b1, 32'h20, 32'hA5A5A5A5, 32'h0, t1, n1);
    drain(0);
    @(negedge clk);
    show_addr = 32'h20;
    @(posedge clk); #1;
    cmp("show_basic", show_data, 32'hA5A5A5A5);
    issue(0, 1'b1, 32'h20, 32'h00000001, 32'h0, t1, n1);
    @(posedge clk);
    @(posedge clk); #1;
    cmp("show_rbw_old", show_data, 32'hA5A5A5A5);
    @(posedge clk); #1;
    cmp("show_rbw_new", show_data, 32'h00000001);
    drain(0);

    // Reset in the middle of a write abandons it
    issue(0, 1'b1, 32'h30, 32'h0BADF00D, 32'h0, t1, n1);
    drain(0);
    issue(0, 1'b1, 32'h30, 32'hFFFFFFFF, 32'h0, t1, n1);
    #3;
    if0.req_valid = 1'b0;
    rst = 1'b1;
    q0.delete();
    last_rd0 = 32'd0;
    last_rd1 = 32'd0;
    #1;
    cmp("midrst_resp_valid", {31'd0, if0.resp_valid}, 32'd0);
    cmp("midrst_busy", {31'd0, if0.busy}, 32'd0);
    cmp("midrst_rdata", if0.resp_rdata, 32'd0);
    cmp("midrst_show", show_data, 32'd0);
    cmp("midrst_misalign", {31'd0, if0.misalign_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    cmp("midrst_ready", {31'd0, if0.req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    issue(0, 1'b0, 32'h30, 32'h0, 32'h0BADF00D, t1, n1);
    drain(0);

    // LATENCY=1 build
    issue(1, 1'b1, 32'h08, 32'h11112222, 32'h0, t1, n1);
    issue(1, 1'b0, 32'h08, 32'h0, 32'h11112222, t1, n1);
    issue(1, 1'b0, 32'h08, 32'h0, 32'h11112222, t2, n2);
    drain(1);
    cmp("lat1_spacing", 32'((t2 - t1) / PERIOD), 32'd3);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
